// File: rtl/c7b_load_pkg.sv
// c7b_load_pkg: shared load opcode encodings, load-unit FSM states and the
// alignment helper used when C7B_LOAD_ALIGN_CHECK_EN is defined.
package c7b_load_pkg;

    // Load opcodes presented on ld_op. Codes 3, 6 and 7 are undefined and behave as LdW.
    typedef enum logic [2:0] {
        LdB  = 3'd0,
        LdH  = 3'd1,
        LdW  = 3'd2,
        LdBu = 3'd4,
        LdHu = 3'd5
    } ld_op_e;

    // Load-unit control states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StResp  = 3'd3,
        StDrain = 3'd4
    } ld_state_e;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned WordW   = 32;

    // True when the access size implied by op does not fit the low address bits.
    // Undefined opcodes are sized as full words.
    function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            LdB, LdBu: mis = 1'b0;
            LdH, LdHu: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/c7b_load_extract.sv
// c7b_load_extract: picks the byte/halfword lane out of a little-endian
// memory word and sign- or zero-extends it to 32 bits. Purely combinational.
module c7b_load_extract
    import c7b_load_pkg::*;
(
    input  logic [2:0]       op_i,
    input  logic [1:0]       addr_i,
    input  logic [WordW-1:0] word_i,
    output logic [WordW-1:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection: byte by addr[1:0], halfword by addr[1] only (addr[0] ignored).
    always_comb begin
        byte_lane = word_i[7:0];
        unique case (addr_i)
            2'd0: byte_lane = word_i[7:0];
            2'd1: byte_lane = word_i[15:8];
            2'd2: byte_lane = word_i[23:16];
            2'd3: byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
        half_lane = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension by opcode; anything that is not a byte/halfword op returns the whole word.
    always_comb begin
        result_o = word_i;
        case (op_i)
            LdB:     result_o = {{24{byte_lane[7]}}, byte_lane};
            LdBu:    result_o = {24'd0, byte_lane};
            LdH:     result_o = {{16{half_lane[15]}}, half_lane};
            LdHu:    result_o = {16'd0, half_lane};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/c7b_load_unit.sv
// c7b_load_unit: single-outstanding load unit between execute and writeback.
// Accepts one load, issues a word-aligned memory read, extracts/extends the
// result and holds it until writeback takes it. Flushes abort the load; a
// read already accepted by memory is drained so its data never reaches wb.
// Optional feature: define C7B_LOAD_ALIGN_CHECK_EN to trap misaligned
// halfword/word loads (no memory access, ale_excp/ale_badv reported instead).
module c7b_load_unit
    import c7b_load_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [2:0]           ld_op,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [RegIdxW-1:0]   ld_rd,
    input  logic                 flush,

    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [RegIdxW-1:0]   wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 ale_excp,
    output logic [ADDR_W-1:0]    ale_badv
);

    ld_state_e           state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [RegIdxW-1:0]  rd_q;
    logic [DATA_W-1:0]   data_q;

    logic                accept;
    logic                rdata_take;
    logic                misaligned;
    logic [WordW-1:0]    extract_result;

    // A flush in the same cycle as ld_valid blocks the accept.
    assign accept     = (state_q == StIdle) & ld_valid & ~flush;
    // Read data is only consumed in WAIT and only if the load is not being flushed.
    assign rdata_take = (state_q == StWait) & mem_rvalid & ~flush;

`ifdef C7B_LOAD_ALIGN_CHECK_EN
    assign misaligned = ld_misaligned(ld_op, ld_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    c7b_load_extract u_extract (
        .op_i     (op_q),
        .addr_i   (addr_q[1:0]),
        .word_i   (mem_rdata),
        .result_o (extract_result)
    );

    // State register; reset abandons any outstanding read without draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = misaligned ? StResp : StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    // Once memory has taken the request its data must still be swallowed.
                    state_d = mem_ack ? StDrain : StIdle;
                end else if (mem_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    // A flush coinciding with the data consumes that beat; nothing left to drain.
                    state_d = flush ? StIdle : StResp;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                if (flush || wb_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request capture and result register; data is cleared at accept so a
    // trapped load reports zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= 3'd0;
            addr_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= ld_op;
                addr_q <= ld_addr;
                rd_q   <= ld_rd;
                data_q <= '0;
            end else if (rdata_take) begin
                data_q <= extract_result;
            end
        end
    end

`ifdef C7B_LOAD_ALIGN_CHECK_EN
    logic              ale_excp_q;
    logic [ADDR_W-1:0] ale_badv_q;

    // Exception status is decided at accept and held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ale_excp_q <= 1'b0;
            ale_badv_q <= '0;
        end else if (accept) begin
            ale_excp_q <= misaligned;
            ale_badv_q <= misaligned ? ld_addr : '0;
        end
    end

    assign ale_excp = ale_excp_q;
    assign ale_badv = ale_badv_q;
`else
    assign ale_excp = 1'b0;
    assign ale_badv = '0;
`endif

    assign ld_ready = (state_q == StIdle);
    assign mem_req  = (state_q == StReq);
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign wb_valid = (state_q == StResp);
    assign wb_rd    = rd_q;
    assign wb_data  = data_q;

endmodule
